// File: rtl/neuron_row_sequencer_pkg.sv
// Shared definitions for the neuron row sequencer: image geometry, datapath widths
// and the sequencer state type.
package neuron_row_sequencer_pkg;

    localparam int unsigned NUM_ROWS     = 28;
    localparam int unsigned PIXEL_W      = 10;
    localparam int unsigned WEIGHT_W     = 19;
    localparam int unsigned BETA_W       = 19;
    localparam int unsigned PIXEL_ROW_W  = NUM_ROWS * PIXEL_W;   // 280
    localparam int unsigned WEIGHT_ROW_W = NUM_ROWS * WEIGHT_W;  // 532

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        BIAS,
        ACT,
        DONE
    } seqState_t;

endpackage

// File: rtl/neuron_row_sequencer_if.sv
// Start/result handshake plus accumulator control bundle between the row
// sequencer (master) and the neuron datapath / result consumer (slave).
interface neuron_row_sequencer_if #(
    parameter int unsigned SEL_W = 5
);

    logic             Input_Valid;
    logic             Out_Ready;
    logic             Input_Ready;
    logic [SEL_W-1:0] Row_Select;
    logic             Acc_Clear;
    logic             Acc_En;
    logic             Bias_En;
    logic             Act_En;
    logic             Busy;
    logic             Out_Valid;
    logic [15:0]      Eval_Count;

    modport master (
        input  Input_Valid, Out_Ready,
        output Input_Ready, Row_Select, Acc_Clear, Acc_En, Bias_En,
               Act_En, Busy, Out_Valid, Eval_Count
    );

    modport slave (
        output Input_Valid, Out_Ready,
        input  Input_Ready, Row_Select, Acc_Clear, Acc_En, Bias_En,
               Act_En, Busy, Out_Valid, Eval_Count
    );

endinterface

// File: rtl/neuron_row_sequencer.sv
// Moore FSM sequencing one neuron evaluation over the image rows: clear, per-row
// accumulate, pipeline drain, bias add, activation capture and result handshake.
module neuron_row_sequencer #(
    parameter int unsigned NUM_ROWS = 28,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned DRAIN_W  = 3
) (
    input  logic                    clk,
    input  logic                    GlobalReset,
    neuron_row_sequencer_if.master  seqIf
);

    import neuron_row_sequencer_pkg::*;

    localparam logic [SEL_W-1:0]   LAST_ROW   = SEL_W'(NUM_ROWS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = (PIPE_LAT == 0) ? '0 : DRAIN_W'(PIPE_LAT - 1);

    seqState_t          state, stateNext;
    logic [SEL_W-1:0]   rowCnt, rowNext;
    logic [DRAIN_W-1:0] drainCnt, drainNext;
    logic [15:0]        evalCnt, evalNext;

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state    <= IDLE;
            rowCnt   <= '0;
            drainCnt <= '0;
            evalCnt  <= '0;
        end else begin
            state    <= stateNext;
            rowCnt   <= rowNext;
            drainCnt <= drainNext;
            evalCnt  <= evalNext;
        end
    end

    always_comb begin
        stateNext = state;
        rowNext   = rowCnt;
        drainNext = drainCnt;
        evalNext  = evalCnt;
        unique case (state)
            IDLE:  if (seqIf.Input_Valid) stateNext = CLEAR;
            CLEAR: begin
                stateNext = ACCUM;
                rowNext   = '0;
            end
            ACCUM: begin
                if (rowCnt == LAST_ROW) begin
                    rowNext = '0;
                    // With no MAC pipeline there is nothing to drain.
                    if (PIPE_LAT == 0) begin
                        stateNext = BIAS;
                    end else begin
                        stateNext = DRAIN;
                        drainNext = DRAIN_INIT;
                    end
                end else begin
                    rowNext = rowCnt + 1'b1;
                end
            end
            DRAIN: begin
                if (drainCnt == '0) stateNext = BIAS;
                else                drainNext = drainCnt - 1'b1;
            end
            BIAS:  stateNext = ACT;
            ACT: begin
                stateNext = DONE;
                evalNext  = evalCnt + 16'd1;
            end
            DONE:  if (seqIf.Out_Ready) stateNext = IDLE;
            default: begin
                stateNext = IDLE;
                rowNext   = '0;
                drainNext = '0;
            end
        endcase
    end

    // Outputs decode from registered state only; Row_Select is forced to 0 outside ACCUM.
    assign seqIf.Input_Ready = (state == IDLE);
    assign seqIf.Busy        = (state != IDLE);
    assign seqIf.Row_Select  = (state == ACCUM) ? rowCnt : '0;
    assign seqIf.Acc_Clear   = (state == CLEAR);
    assign seqIf.Acc_En      = (state == ACCUM);
    assign seqIf.Bias_En     = (state == BIAS);
    assign seqIf.Act_En      = (state == ACT);
    assign seqIf.Out_Valid   = (state == DONE);
    assign seqIf.Eval_Count  = evalCnt;

endmodule
